// File: rtl/prog_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : prog_loader                                                 |
// | Desc     : Byte-stream program loader. Receives a 16-bit word count,   |
// |            N little-endian 32-bit words and an XOR checksum, writes    |
// |            the words to instruction memory and releases core reset     |
// |            once the checksum matches.                                  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module prog_loader #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LEN_LO = 3'd1;
  localparam logic [2:0] c_ST_LEN_HI = 3'd2;
  localparam logic [2:0] c_ST_DATA   = 3'd3;
  localparam logic [2:0] c_ST_CHK    = 3'd4;
  localparam logic [2:0] c_ST_RUN    = 3'd5;
  localparam logic [2:0] c_ST_ERR    = 3'd6;

  localparam logic [15:0] c_DEPTH = 16'(DEPTH_WORDS);

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [23:0] word_q, word_d;       // first three bytes of the word in flight
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        byte_ready_q, byte_ready_d;
  logic        core_rst_q, core_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // byte_ready_q is registered from the next state, so it always reflects
  // the current state and can gate the handshake directly.
  logic        w_xfer;
  logic [15:0] w_len_full;
  assign w_xfer     = byte_valid & byte_ready_q;
  assign w_len_full = {byte_data, len_q[7:0]};

  // State register; reset dominates every other condition.
  always_ff @(posedge clk) begin
    if (rst) state_q <= c_ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE, c_ST_RUN, c_ST_ERR: if (start) state_d = c_ST_LEN_LO;
      c_ST_LEN_LO: if (w_xfer) state_d = c_ST_LEN_HI;
      c_ST_LEN_HI: begin
        if (w_xfer) begin
          if (w_len_full > c_DEPTH)    state_d = c_ST_ERR;
          else if (w_len_full == 16'd0) state_d = c_ST_CHK;
          else                          state_d = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_xfer && (byte_idx_q == 2'd3) && (word_idx_q == (len_q - 16'd1)))
          state_d = c_ST_CHK;
      end
      c_ST_CHK: begin
        if (w_xfer) state_d = (byte_data == chk_q) ? c_ST_RUN : c_ST_ERR;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // Status outputs decoded from the next state so they are registered in step with it.
  always_comb begin
    byte_ready_d = (state_d == c_ST_LEN_LO) || (state_d == c_ST_LEN_HI) ||
                   (state_d == c_ST_DATA)   || (state_d == c_ST_CHK);
    busy_d       = byte_ready_d;
    done_d       = (state_d == c_ST_RUN);
    err_d        = (state_d == c_ST_ERR);
    core_rst_d   = (state_d != c_ST_RUN);
  end

  // Status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_rst_q   <= 1'b1;
    end else begin
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_rst_q   <= core_rst_d;
    end
  end

  // Datapath: length capture, word packing, checksum and memory write strobe.
  always_comb begin
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    chk_d        = chk_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      c_ST_IDLE, c_ST_RUN, c_ST_ERR: begin
        if (start) begin
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
          chk_d      = 8'd0;
        end
      end
      c_ST_LEN_LO: if (w_xfer) len_d[7:0]  = byte_data;
      c_ST_LEN_HI: if (w_xfer) len_d[15:8] = byte_data;
      c_ST_DATA: begin
        if (w_xfer) begin
          chk_d      = chk_q ^ byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0:    word_d[7:0]   = byte_data;
            2'd1:    word_d[15:8]  = byte_data;
            2'd2:    word_d[23:16] = byte_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = {14'd0, word_idx_q, 2'b00};
              imem_wdata_d = {byte_data, word_q};
              word_idx_d   = word_idx_q + 16'd1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_idx_q   <= 2'd0;
      chk_q        <= 8'd0;
      word_q       <= 24'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
    end else begin
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      chk_q        <= chk_d;
      word_q       <= word_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_prog_loader                                              |
// | Desc     : Directed self-checking bench for prog_loader with a write   |
// |            scoreboard.                                                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, imem_we, core_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  logic [63:0] sb[$];

  prog_loader #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      writes++;
      if (sb.size() == 0) begin
        check("unexpected_we", {31'd0, imem_we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offer one byte until it is accepted, optionally with random idle cycles.
  task automatic send(input logic [7:0] b, input bit gaps);
    bit sent = 1'b0;
    bit rdy;
    int n = 0;
    while (!sent && n < 100) begin
      @(negedge clk);
      rdy = (byte_ready === 1'b1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        sent       = rdy;
      end
      @(posedge clk); #1 byte_valid = 1'b0;
      n++;
    end
    if (!sent) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gaps);
    sb.push_back({addr, w});
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gaps);
  endtask

  task automatic nominal(input logic [7:0] chk, input bit gaps);
    send(8'h02, gaps); send(8'h00, gaps);
    send_word(32'h0000_0013, 32'h0, gaps);
    send_word(32'h0010_0093, 32'h4, gaps);
    send(chk, gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w0;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);

    // Nominal load
    w0 = writes;
    pulse_start();
    @(negedge clk);
    check("start_busy", {30'd0, busy, byte_ready}, 32'd3);
    check("start_core_rst", {31'd0, core_rst}, 32'd1);
    nominal(8'h90, 1'b0);
    @(negedge clk);
    check("nom_done", {29'd0, busy, done, err}, 32'b010);
    check("nom_core_rst", {31'd0, core_rst}, 32'd0);
    check("nom_writes", 32'(writes - w0), 32'd2);
    check("nom_sb_empty", 32'(sb.size()), 32'd0);

    // Bytes offered in RUN are not consumed
    @(negedge clk); byte_valid = 1'b1; byte_data = 8'hAA;
    idle(4); byte_valid = 1'b0;
    check("run_hold", {29'd0, busy, done, err}, 32'b010);
    check("run_ready", {31'd0, byte_ready}, 32'd0);

    // Restart from RUN reasserts core reset next cycle
    pulse_start();
    @(negedge clk);
    check("restart_core_rst", {31'd0, core_rst}, 32'd1);
    check("restart_busy", {29'd0, busy, done, err}, 32'b100);

    // Bad checksum, with an ignored start in the middle of DATA
    w0 = writes;
    send(8'h02, 1'b0); send(8'h00, 1'b0);
    send_word(32'h0000_0013, 32'h0, 1'b0);
    pulse_start();
    send_word(32'h0010_0093, 32'h4, 1'b0);
    send(8'h91, 1'b0);
    @(negedge clk);
    check("badchk_flags", {29'd0, busy, done, err}, 32'b001);
    check("badchk_core_rst", {31'd0, core_rst}, 32'd1);
    check("badchk_writes", 32'(writes - w0), 32'd2);
    pulse_start();
    @(negedge clk);
    check("err_restart", {29'd0, busy, done, err}, 32'b100);

    // Oversize (65 words)
    w0 = writes;
    send(8'h41, 1'b0); send(8'h00, 1'b0);
    @(negedge clk);
    check("oversize_err", {29'd0, busy, done, err}, 32'b001);
    idle(3);
    check("oversize_writes", 32'(writes - w0), 32'd0);

    // Exactly DEPTH_WORDS is accepted, then abandoned by reset with start held
    pulse_start();
    send(8'h40, 1'b0); send(8'h00, 1'b0);
    @(negedge clk);
    check("maxlen_busy", {29'd0, busy, done, err}, 32'b100);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_dominant", {29'd0, busy, done, err}, 32'b000);

    // Zero-length loads
    w0 = writes;
    pulse_start();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    @(negedge clk);
    check("zero_ok", {29'd0, busy, done, err}, 32'b010);
    pulse_start();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
    @(negedge clk);
    check("zero_bad", {29'd0, busy, done, err}, 32'b001);
    check("zero_writes", 32'(writes - w0), 32'd0);

    // Nominal stream with handshake gaps
    w0 = writes;
    pulse_start();
    nominal(8'h90, 1'b1);
    @(negedge clk);
    check("gap_done", {29'd0, busy, done, err}, 32'b010);
    check("gap_core_rst", {31'd0, core_rst}, 32'd0);
    check("gap_writes", 32'(writes - w0), 32'd2);

    // Reset after five DATA bytes
    w0 = writes;
    pulse_start();
    send(8'h02, 1'b0); send(8'h00, 1'b0);
    send_word(32'h0000_0013, 32'h0, 1'b0);
    send(8'h93, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_flags", {29'd0, busy, done, err}, 32'b000);
    check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
    byte_valid = 1'b1; byte_data = 8'h55;
    idle(10); byte_valid = 1'b0;
    check("midrst_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_writes", 32'(writes - w0), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #200000;
    miscompares++;
    $display("FAIL global_timeout: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
